// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Display data is double-buffered: a load strobe fills a pending buffer, which
// is committed to the active buffer only at the end of a frame so a frame never
// shows a mix of old and new values. All pin outputs are active-low and registered.
module seven_seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_blank,
   input  logic                    load,
   output logic                    pending,
   output logic                    frame_done,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              display,
   output logic                    dp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]       SEG_OFF   = 7'b1111111;

   // Everything needed to draw one frame.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
      logic                    lz;
   } frame_t;

   localparam frame_t ACTIVE_RESET = '{digits: '0, dp: '0, blank: '1, lz: 1'b0};

   // Segment pattern {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] hex_glyph(input logic [3:0] value);
      case (value)
         4'h0:    hex_glyph = 7'b1000000;
         4'h1:    hex_glyph = 7'b1111001;
         4'h2:    hex_glyph = 7'b0100100;
         4'h3:    hex_glyph = 7'b0110000;
         4'h4:    hex_glyph = 7'b0011001;
         4'h5:    hex_glyph = 7'b0010010;
         4'h6:    hex_glyph = 7'b0000010;
         4'h7:    hex_glyph = 7'b1111000;
         4'h8:    hex_glyph = 7'b0000000;
         4'h9:    hex_glyph = 7'b0010000;
         4'hA:    hex_glyph = 7'b0001000;
         4'hB:    hex_glyph = 7'b0000011;
         4'hC:    hex_glyph = 7'b1000110;
         4'hD:    hex_glyph = 7'b0100001;
         4'hE:    hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   logic [CNT_W-1:0]      slot_cnt;
   logic [IDX_W-1:0]      digit_idx;
   logic                  slot_last;
   logic                  commit;
   frame_t                pend_buf;
   frame_t                act_buf;
   frame_t                in_frame;
   logic                  lz_chain;
   logic [NUM_DIGITS-1:0] lz_dark;
   logic [3:0]            cur_val;
   logic                  cur_dark;
   logic                  cur_dp;
   logic                  visible;
   logic [NUM_DIGITS-1:0] anode_next;

   assign slot_last = (slot_cnt == LAST_SLOT);
   assign commit    = slot_last && (digit_idx == LAST_IDX) && pending;
   assign in_frame  = '{digits: digits_in, dp: dp_in, blank: blank_in, lz: lz_blank};

   // Slot counter and digit index: the scan position.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else if (slot_last) begin
         slot_cnt  <= '0;
         digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
      end else begin
         slot_cnt  <= slot_cnt + CNT_W'(1);
      end
   end

   // Pending/active double buffer with commit at the last cycle of each frame.
   always_ff @(posedge clk) begin
      // NOTE: both buffers are reset; the active one comes up fully blanked so
      // the display stays dark until the first commit.
      if (reset) begin
         pend_buf   <= '0;
         act_buf    <= ACTIVE_RESET;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= commit;
         if (commit) begin
            act_buf <= pend_buf;
         end
         if (load) begin
            pend_buf <= in_frame;
            pending  <= 1'b1;
         end else if (commit) begin
            pending  <= 1'b0;
         end
      end
   end

   // Blanking and visibility of the digit currently being scanned.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      lz_chain   = act_buf.lz;
      lz_dark    = '0;
      cur_val    = 4'h0;
      cur_dark   = 1'b1;
      cur_dp     = 1'b0;
      anode_next = '1;
      // Leading-zero blanking runs from the leftmost digit down and stops at the
      // first nonzero digit or lit decimal point; digit 0 is never LZ-blanked.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_chain   = lz_chain && (act_buf.digits[4*i +: 4] == 4'h0) && !act_buf.dp[i];
         lz_dark[i] = lz_chain;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_val  = act_buf.digits[4*i +: 4];
            cur_dark = act_buf.blank[i] | lz_dark[i];
            cur_dp   = act_buf.dp[i];
         end
      end
      visible = (slot_cnt >= GUARD_CNT) && !cur_dark;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         anode_next[i] = !(visible && (digit_idx == IDX_W'(i)));
      end
   end

   // Registered pin drivers, one cycle behind the scan position.
   always_ff @(posedge clk) begin
      if (reset) begin
         anode   <= '1;
         display <= SEG_OFF;
         dp      <= 1'b1;
      end else begin
         anode   <= anode_next;
         display <= visible ? hex_glyph(cur_val) : SEG_OFF;
         dp      <= !(visible && cur_dp);
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan. A frame-level reference model predicts
// the pins after every clock edge and queues the prediction; a monitor on the
// falling edge pops each prediction and compares it with the DUT pins.
module tb_seven_seg_scan;

   localparam int N     = 4;
   localparam int RD    = 8;
   localparam int G     = 2;
   localparam int FRAME = N * RD;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4*N-1:0]   digits_in = '0;
   logic [N-1:0]     dp_in = '0;
   logic [N-1:0]     blank_in = '0;
   logic             lz_blank = 1'b0;
   logic             load = 1'b0;
   logic             pending;
   logic             frame_done;
   logic [N-1:0]     anode;
   logic [6:0]       display;
   logic             dp;

   seven_seg_scan #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(RD),
      .GUARD      (G)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .blank_in  (blank_in),
      .lz_blank  (lz_blank),
      .load      (load),
      .pending   (pending),
      .frame_done(frame_done),
      .anode     (anode),
      .display   (display),
      .dp        (dp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] anode;
      logic [6:0]   display;
      logic         dp;
      logic         pending;
      logic         frame_done;
   } obs_t;

   localparam obs_t RESET_OBS = '{anode: '1, display: 7'b1111111, dp: 1'b1,
                                  pending: 1'b0, frame_done: 1'b0};

   logic [6:0] glyph [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   obs_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    started = 1'b0;
   string phase = "reset";

   // Reference model: cycles since reset, the frame shown, and the pending frame.
   int         m_t = 0;
   logic [3:0] m_val [N];
   logic [N-1:0] m_dp, m_blank;
   logic       m_lz;
   logic [3:0] p_val [N];
   logic [N-1:0] p_dp, p_blank;
   logic       p_lz;
   logic       p_flag;

   task automatic check(input string name, input obs_t got, input obs_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s @%0t: got anode=%b display=%b dp=%b pending=%b frame_done=%b, expected anode=%b display=%b dp=%b pending=%b frame_done=%b",
                  name, $time, got.anode, got.display, got.dp, got.pending, got.frame_done,
                  want.anode, want.display, want.dp, want.pending, want.frame_done);
      end
   endtask

   // Pins expected after an edge taken at frame position pos.
   function automatic obs_t model_view(input int pos);
      obs_t o;
      int   idx;
      int   slot;
      int   msd;
      bit   vis;
      idx  = pos / RD;
      slot = pos % RD;
      // Highest digit that is nonzero or carries a decimal point; everything
      // above it is a leading zero.
      msd = -1;
      for (int i = 0; i < N; i++) begin
         if (m_val[i] != 4'h0 || m_dp[i]) msd = i;
      end
      vis = (slot >= G) && !m_blank[idx] && !(m_lz && idx > 0 && idx > msd);
      o = RESET_OBS;
      if (vis) begin
         o.anode[idx] = 1'b0;
         o.display    = glyph[m_val[idx]];
         o.dp         = !m_dp[idx];
      end
      return o;
   endfunction

   // Model step at every rising edge; the prediction goes to the scoreboard.
   always @(posedge clk) begin
      obs_t e;
      int   pos;
      bit   commit;
      if (reset) begin
         e = RESET_OBS;
         m_t = 0;
         for (int i = 0; i < N; i++) begin
            m_val[i] = 4'h0;
            p_val[i] = 4'h0;
         end
         m_dp = '0; m_blank = '1; m_lz = 1'b0;
         p_dp = '0; p_blank = '0; p_lz = 1'b0; p_flag = 1'b0;
      end else begin
         pos    = m_t % FRAME;
         e      = model_view(pos);
         commit = (pos == FRAME - 1) && p_flag;
         if (commit) begin
            m_val = p_val; m_dp = p_dp; m_blank = p_blank; m_lz = p_lz;
            p_flag = 1'b0;
         end
         if (load) begin
            for (int i = 0; i < N; i++) p_val[i] = digits_in[4*i +: 4];
            p_dp = dp_in; p_blank = blank_in; p_lz = lz_blank; p_flag = 1'b1;
         end
         e.pending    = p_flag;
         e.frame_done = commit;
         m_t++;
      end
      exp_q.push_back(e);
      started = 1'b1;
   end

   // Monitor: compare DUT pins with the oldest prediction on the falling edge.
   always @(negedge clk) begin
      obs_t got;
      if (started) begin
         got = '{anode: anode, display: display, dp: dp, pending: pending, frame_done: frame_done};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty @%0t: got no prediction, expected one per cycle", $time);
         end else begin
            check(phase, got, exp_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dpv,
                          input logic [N-1:0] blk, input logic lz);
      digits_in = d; dp_in = dpv; blank_in = blk; lz_blank = lz; load = 1'b1;
      tick(1);
      load      = 1'b0;
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      blank_in  = 4'($urandom);
      lz_blank  = 1'($urandom);
   endtask

   // Advance until the scan sits at frame position p (so an input set now is
   // sampled at the edge taken from position p).
   task automatic wait_pos(input int p);
      int budget;
      budget = 2 * FRAME + 2;
      while ((m_t % FRAME) != p && budget > 0) begin
         tick(1);
         budget--;
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL wait_pos @%0t: got position %0d, expected %0d", $time, m_t % FRAME, p);
      end
   endtask

   task automatic rand_load();
      logic [4*N-1:0] d;
      for (int i = 0; i < N; i++) begin
         d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      do_load(d, 4'($urandom & $urandom & $urandom), 4'($urandom & $urandom),
              1'($urandom_range(0, 1)));
   endtask

   initial begin
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      phase = "reset_idle";
      tick(5 * FRAME);

      phase = "basic_12AF";
      do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
      tick(3 * FRAME);

      phase = "lz_0040";
      do_load(16'h0040, 4'b0000, 4'b0000, 1'b1);
      tick(2 * FRAME);
      phase = "lz_0000";
      do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
      tick(2 * FRAME);
      phase = "lz_0000_dp2";
      do_load(16'h0000, 4'b0100, 4'b0000, 1'b1);
      tick(2 * FRAME);

      phase = "last_load_wins";
      wait_pos(3);
      do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
      tick(5);
      do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
      phase = "load_on_commit";
      wait_pos(FRAME - 1);
      do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
      tick(3 * FRAME);

      phase = "blank_mask";
      do_load(16'h8888, 4'b0000, 4'b1010, 1'b0);
      tick(2 * FRAME);

      phase = "reset_mid_scan";
      wait_pos(2 * RD + 3);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2 * FRAME);

      phase = "random";
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) wait_pos(FRAME - 1);
         else tick($urandom_range(1, 40));
         rand_load();
      end
      tick(2 * FRAME);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
